// File: rtl/lcd_pkg.sv
// Shared types and constants for the character-LCD Avalon master.
package lcd_pkg;

    typedef enum logic [2:0] {
        PWRUP = 3'd0,
        WR    = 3'd1,
        WGAP  = 3'd2,
        RD    = 3'd3,
        RGAP  = 3'd4,
        IDLE  = 3'd5
    } lcd_state_t;

    // Slave address is {RS,RW}
    localparam logic [1:0] ADDR_CMD_WR    = 2'd0;
    localparam logic [1:0] ADDR_STATUS_RD = 2'd1;
    localparam logic [1:0] ADDR_DATA_WR   = 2'd2;

    // Entry 0 is the least significant byte: function set, display on, clear, entry mode
    localparam logic [3:0][7:0] INIT_ROM = {8'h06, 8'h01, 8'h0C, 8'h38};

    localparam int BUSY_BIT = 7;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/lcd_cycle_timer.sv
// Loadable down-counter; done is high for the single cycle in which the count is 1,
// so a load of N at one edge makes the following state last exactly N cycles.
module lcd_cycle_timer #(
    parameter int WIDTH      = 20,
    parameter int INIT_COUNT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             done
);

    logic [WIDTH-1:0] count_r;

    // Count register; reset reloads the power-up delay so PWRUP times itself.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= WIDTH'(INIT_COUNT);
        end else if (load) begin
            count_r <= load_value;
        end else if (count_r != {WIDTH{1'b0}}) begin
            count_r <= count_r - WIDTH'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign done = (count_r == WIDTH'(1));

endmodule

// File: rtl/lcd_display_master.sv
// Avalon-MM master sequencing HD44780 init, timed write strobes and busy-flag polling
// on behalf of a simple valid/ready command stream.
module lcd_display_master
    import lcd_pkg::*;
#(
    parameter int E_CYCLES       = 25,
    parameter int GAP_CYCLES     = 2,
    parameter int POWERUP_CYCLES = 750000,
    parameter int POLL_LIMIT     = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rs,
    input  logic [7:0] cmd_data,
    output logic       init_done,
    output logic       busy_timeout,
    output logic [1:0] av_address,
    output logic       av_begintransfer,
    output logic       av_read,
    output logic       av_write,
    output logic [7:0] av_writedata,
    input  logic [7:0] av_readdata
);

    localparam int MAX_CYC = max3(POWERUP_CYCLES, E_CYCLES, GAP_CYCLES);
    localparam int TW      = $clog2(MAX_CYC + 1);
    localparam int PW      = $clog2(POLL_LIMIT + 1);

    lcd_state_t      state_r;
    logic [1:0]      init_idx_r;
    logic [PW-1:0]   poll_cnt_r;
    logic            busy_r;
    logic            timer_done_s;
    logic            load_s;
    logic [TW-1:0]   load_val_s;

    lcd_cycle_timer #(
        .WIDTH      (TW),
        .INIT_COUNT (POWERUP_CYCLES)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (load_s),
        .load_value (load_val_s),
        .done       (timer_done_s)
    );

    // Reload the timer on every state exit; strobe states are followed by gaps and vice versa.
    always_comb begin
        load_s     = 1'b0;
        load_val_s = TW'(E_CYCLES);
        if (state_r == IDLE) begin
            load_s = cmd_valid;
        end else begin
            load_s = timer_done_s;
        end
        if ((state_r == WR) || (state_r == RD)) begin
            load_val_s = TW'(GAP_CYCLES);
        end else begin
            load_val_s = TW'(E_CYCLES);
        end
    end

    // Main sequencer with registered bus and handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r          <= PWRUP;
            init_idx_r       <= 2'd0;
            poll_cnt_r       <= {PW{1'b0}};
            busy_r           <= 1'b0;
            cmd_ready        <= 1'b0;
            init_done        <= 1'b0;
            busy_timeout     <= 1'b0;
            av_address       <= 2'd0;
            av_begintransfer <= 1'b0;
            av_read          <= 1'b0;
            av_write         <= 1'b0;
            av_writedata     <= 8'd0;
        end else begin
            case (state_r)
                PWRUP: begin
                    if (timer_done_s) begin
                        state_r          <= WR;
                        av_write         <= 1'b1;
                        av_begintransfer <= 1'b1;
                        av_address       <= ADDR_CMD_WR;
                        av_writedata     <= INIT_ROM[init_idx_r];
                        poll_cnt_r       <= {PW{1'b0}};
                    end
                end
                WR: begin
                    av_begintransfer <= 1'b0;
                    if (timer_done_s) begin
                        av_write <= 1'b0;
                        state_r  <= WGAP;
                    end
                end
                WGAP: begin
                    if (timer_done_s) begin
                        state_r          <= RD;
                        av_read          <= 1'b1;
                        av_begintransfer <= 1'b1;
                        av_address       <= ADDR_STATUS_RD;
                        poll_cnt_r       <= poll_cnt_r + PW'(1);
                    end
                end
                RD: begin
                    av_begintransfer <= 1'b0;
                    if (timer_done_s) begin
                        av_read <= 1'b0;
                        busy_r  <= av_readdata[BUSY_BIT];
                        state_r <= RGAP;
                    end
                end
                RGAP: begin
                    if (timer_done_s) begin
                        if (busy_r && (poll_cnt_r < PW'(POLL_LIMIT))) begin
                            state_r          <= RD;
                            av_read          <= 1'b1;
                            av_begintransfer <= 1'b1;
                            av_address       <= ADDR_STATUS_RD;
                            poll_cnt_r       <= poll_cnt_r + PW'(1);
                        end else begin
                            // A poll that exhausts the limit is treated as not busy.
                            if (busy_r) begin
                                busy_timeout <= 1'b1;
                            end
                            if (init_done) begin
                                state_r   <= IDLE;
                                cmd_ready <= 1'b1;
                            end else if (init_idx_r == 2'd3) begin
                                init_done <= 1'b1;
                                state_r   <= IDLE;
                                cmd_ready <= 1'b1;
                            end else begin
                                init_idx_r       <= init_idx_r + 2'd1;
                                state_r          <= WR;
                                av_write         <= 1'b1;
                                av_begintransfer <= 1'b1;
                                av_address       <= ADDR_CMD_WR;
                                av_writedata     <= INIT_ROM[init_idx_r + 2'd1];
                                poll_cnt_r       <= {PW{1'b0}};
                            end
                        end
                    end
                end
                IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready        <= 1'b0;
                        state_r          <= WR;
                        av_write         <= 1'b1;
                        av_begintransfer <= 1'b1;
                        av_address       <= {cmd_rs, 1'b0};
                        av_writedata     <= cmd_data;
                        poll_cnt_r       <= {PW{1'b0}};
                    end
                end
                default: begin
                    state_r          <= PWRUP;
                    cmd_ready        <= 1'b0;
                    av_read          <= 1'b0;
                    av_write         <= 1'b0;
                    av_begintransfer <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_display_master.sv
// Randomized bench: a cycle-timeline model of the LCD bus protocol drives stimulus and
// predicts every output; a negedge process compares the DUT against it.
module tb_lcd_display_master;

    localparam int E  = 4;
    localparam int G  = 2;
    localparam int P  = 100;
    localparam int PL = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_rs;
    logic [7:0] cmd_data;
    logic       init_done;
    logic       busy_timeout;
    logic [1:0] av_address;
    logic       av_begintransfer;
    logic       av_read;
    logic       av_write;
    logic [7:0] av_writedata;
    logic [7:0] av_readdata;

    always #5 clk = ~clk;

    lcd_display_master #(
        .E_CYCLES       (E),
        .GAP_CYCLES     (G),
        .POWERUP_CYCLES (P),
        .POLL_LIMIT     (PL)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_rs           (cmd_rs),
        .cmd_data         (cmd_data),
        .init_done        (init_done),
        .busy_timeout     (busy_timeout),
        .av_address       (av_address),
        .av_begintransfer (av_begintransfer),
        .av_read          (av_read),
        .av_write         (av_write),
        .av_writedata     (av_writedata),
        .av_readdata      (av_readdata)
    );

    int   n_total = 0;
    int   n_bad   = 0;
    int   cyc_n   = 0;
    int   rd_cnt  = 0;
    bit   chk_en  = 1'b0;

    logic       exp_write, exp_read, exp_begin, exp_ready;
    logic [1:0] exp_addr;
    logic [7:0] exp_data;
    bit         m_init_done, m_timeout;
    bit         nxt_reset, nxt_valid, nxt_rs;
    logic [7:0] nxt_data;
    logic [7:0] rom [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc_n, got, want);
        end
    endtask

    // Per-cycle comparison of every output against the model's expectation.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("av_write", 32'(av_write), 32'(exp_write));
            chk("av_read", 32'(av_read), 32'(exp_read));
            chk("av_begintransfer", 32'(av_begintransfer), 32'(exp_begin));
            chk("cmd_ready", 32'(cmd_ready), 32'(exp_ready));
            chk("init_done", 32'(init_done), 32'(m_init_done));
            chk("busy_timeout", 32'(busy_timeout), 32'(m_timeout));
            chk("rw_exclusive", 32'(av_read & av_write), 32'd0);
            if (exp_write || exp_read) chk("av_address", 32'(av_address), 32'(exp_addr));
            if (exp_write) chk("av_writedata", 32'(av_writedata), 32'(exp_data));
            if (av_read && av_begintransfer) rd_cnt++;
        end
    end

    // One clock of the timeline: publish expectations, drive inputs, advance.
    task automatic cyc(input logic w, input logic r, input logic b, input logic [1:0] a,
                       input logic [7:0] d, input logic rdy, input logic [7:0] rdata);
        exp_write = w; exp_read = r; exp_begin = b;
        exp_addr = a; exp_data = d; exp_ready = rdy;
        av_readdata = rdata;
        reset = nxt_reset;
        if (nxt_valid) begin
            cmd_valid = 1'b1; cmd_rs = nxt_rs; cmd_data = nxt_data;
        end else begin
            cmd_valid = rdy ? 1'b0 : 1'($urandom_range(0, 1));
            cmd_rs    = 1'($urandom);
            cmd_data  = 8'($urandom);
        end
        nxt_reset = 1'b0;
        nxt_valid = 1'b0;
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic idle_cyc();
        cyc(1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 1'b1, 8'($urandom));
    endtask

    // Full write transaction: strobe, gap, then polls until not busy or the limit.
    task automatic do_write(input logic rs, input logic [7:0] d, input int busy_polls, output int n);
        logic [1:0] a;
        bit busy;
        a = rs ? 2'd2 : 2'd0;
        for (int i = 0; i < E; i++) cyc(1'b1, 1'b0, (i == 0), a, d, 1'b0, 8'($urandom));
        for (int i = 0; i < G; i++) cyc(1'b0, 1'b0, 1'b0, a, d, 1'b0, 8'($urandom));
        n = 0;
        do begin
            n++;
            busy = (n <= busy_polls);
            for (int i = 0; i < E; i++)
                cyc(1'b0, 1'b1, (i == 0), 2'd1, d, 1'b0,
                    (i == E - 1) ? {busy, 7'($urandom)} : 8'($urandom));
            for (int i = 0; i < G; i++) cyc(1'b0, 1'b0, 1'b0, 2'd1, d, 1'b0, 8'($urandom));
        end while (busy && n < PL);
        if (busy) m_timeout = 1'b1;
    endtask

    task automatic send(input logic rs, input logic [7:0] d, input int busy_polls, output int n);
        nxt_valid = 1'b1; nxt_rs = rs; nxt_data = d;
        idle_cyc();
        do_write(rs, d, busy_polls, n);
    endtask

    // Everything after a reset edge: silent power-up delay, then the four init writes.
    task automatic post_reset(input int max_busy);
        int n;
        m_init_done = 1'b0;
        m_timeout   = 1'b0;
        for (int i = 0; i < P; i++) cyc(1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 8'($urandom));
        for (int k = 0; k < 4; k++) do_write(1'b0, rom[k], $urandom_range(0, max_busy), n);
        m_init_done = 1'b1;
    endtask

    initial begin
        int t, n, bp;
        reset = 1'b1; cmd_valid = 1'b1; cmd_rs = 1'b0; cmd_data = 8'h00; av_readdata = 8'h00;
        nxt_reset = 1'b0; nxt_valid = 1'b0; nxt_rs = 1'b0; nxt_data = 8'h00;
        m_init_done = 1'b0; m_timeout = 1'b0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;

        t = cyc_n;
        post_reset(0);
        chk("init_length", 32'(cyc_n - t), 32'd148);

        idle_cyc(); idle_cyc();
        t = cyc_n; rd_cnt = 0;
        send(1'b1, 8'h41, 0, n);
        chk("cmd_to_ready", 32'(cyc_n - t), 32'd13);
        chk("polls_not_busy", 32'(n), 32'd1);
        chk("reads_not_busy", 32'(rd_cnt), 32'd1);

        idle_cyc();
        rd_cnt = 0;
        send(1'b0, 8'h80, 3, n);
        chk("polls_busy3", 32'(n), 32'd4);
        chk("reads_busy3", 32'(rd_cnt), 32'd4);
        chk("timeout_busy3", 32'(busy_timeout), 32'd0);

        rd_cnt = 0;
        send(1'b1, 8'h7E, 1000, n);
        chk("polls_forever", 32'(n), 32'd8);
        chk("reads_forever", 32'(rd_cnt), 32'd8);
        chk("timeout_forever", 32'(busy_timeout), 32'd1);
        chk("ready_after_timeout", 32'(cmd_ready), 32'd1);

        for (int k = 0; k < 25; k++) begin
            for (int j = $urandom_range(0, 3); j > 0; j--) idle_cyc();
            bp = ($urandom_range(0, 7) == 0) ? 1000 : $urandom_range(0, 3);
            send(1'($urandom), 8'($urandom), bp, n);
        end
        chk("timeout_sticky", 32'(busy_timeout), 32'd1);

        // Reset lands on the second clock of a data write.
        idle_cyc();
        nxt_valid = 1'b1; nxt_rs = 1'b1; nxt_data = 8'h5A;
        idle_cyc();
        cyc(1'b1, 1'b0, 1'b1, 2'd2, 8'h5A, 1'b0, 8'($urandom));
        nxt_reset = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 2'd2, 8'h5A, 1'b0, 8'($urandom));
        chk("abort_write", 32'(av_write), 32'd0);
        chk("abort_init_done", 32'(init_done), 32'd0);
        post_reset(2);

        idle_cyc();
        send(1'b1, 8'h21, 1, n);
        chk("final_polls", 32'(n), 32'd2);
        idle_cyc();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
